// File: rtl/glb_pkg.sv
// glb_pkg: shared global-buffer bank constants and request bundles
package glb_pkg;
    localparam int BANK_DATA_WIDTH = 64;
    localparam int BANK_ADDR_WIDTH = 14;
    localparam int SRAM_READ_LATENCY = 3;
    typedef struct packed {
        logic [BANK_ADDR_WIDTH-1:0]   addr;
        logic [BANK_DATA_WIDTH-1:0]   data;
        logic [BANK_DATA_WIDTH/8-1:0] strb;
    } bank_wr_req_t;
    typedef struct packed {
        logic [BANK_ADDR_WIDTH-1:0] addr;
    } bank_rd_req_t;
endpackage

// File: rtl/glb_bank_resp_fifo.sv
// glb_bank_resp_fifo: synchronous FIFO with occupancy count; push into a full FIFO succeeds only alongside a pop
module glb_bank_resp_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign pop_data = mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= push_data;
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/glb_bank_mem_ctrl.sv
// glb_bank_mem_ctrl: write/read arbiter and SRAM driver for one global-buffer bank,
// with fixed-latency read tracking into a credit-protected response FIFO
module glb_bank_mem_ctrl
    import glb_pkg::*;
#(
    parameter int DATA_WIDTH = BANK_DATA_WIDTH,
    parameter int ADDR_WIDTH = BANK_ADDR_WIDTH,
    parameter int READ_LATENCY = SRAM_READ_LATENCY,
    parameter int RESP_FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_req_valid,
    output logic                    wr_req_ready,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic                    rd_req_valid,
    output logic                    rd_req_ready,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic                    rd_resp_valid,
    input  logic                    rd_resp_ready,
    output logic [DATA_WIDTH-1:0]   rd_resp_data,
    output logic                    mem_ceb,
    output logic                    mem_web,
    output logic [DATA_WIDTH-1:0]   mem_bweb,
    output logic [ADDR_WIDTH-1:0]   mem_a,
    output logic [DATA_WIDTH-1:0]   mem_d,
    input  logic [DATA_WIDTH-1:0]   mem_q
);
    localparam int CW = $clog2(RESP_FIFO_DEPTH+1);
    logic last_wr, rd_ok, wr_gnt, rd_gnt, push, pop, fifo_full, fifo_empty;
    logic [CW-1:0] credits, fifo_count;
    logic [READ_LATENCY-1:0] lat;
    // credits cover in-flight reads too, so a granted read always has a FIFO slot waiting
    assign rd_ok = rd_req_valid && credits < CW'(RESP_FIFO_DEPTH);
    assign wr_gnt = !reset && wr_req_valid && (!rd_ok || !last_wr);
    assign rd_gnt = !reset && rd_ok && (!wr_req_valid || last_wr);
    assign wr_req_ready = wr_gnt;
    assign rd_req_ready = rd_gnt;
    assign mem_ceb = !(wr_gnt || rd_gnt);
    assign mem_web = !wr_gnt;
    assign mem_a = wr_gnt ? wr_addr : rd_gnt ? rd_addr : '0;
    assign mem_d = wr_gnt ? wr_data : '0;
    for (genvar b = 0; b < DATA_WIDTH/8; b++) begin : g_bweb
        assign mem_bweb[b*8 +: 8] = wr_gnt ? {8{~wr_strb[b]}} : 8'hFF;
    end
    assign push = lat[READ_LATENCY-1];
    assign pop = rd_resp_valid && rd_resp_ready;
    assign rd_resp_valid = !fifo_empty;
    always_ff @(posedge clk) begin
        if (reset) begin
            last_wr <= 1'b0;
            lat <= '0;
            credits <= '0;
        end else begin
            if (wr_gnt || rd_gnt) last_wr <= wr_gnt;
            lat <= {lat[READ_LATENCY-2:0], rd_gnt};
            credits <= credits + CW'(rd_gnt) - CW'(pop);
            assert (!(push && fifo_full));
            assert (credits >= fifo_count);
        end
    end
    glb_bank_resp_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RESP_FIFO_DEPTH)) u_resp_fifo (
        .clk(clk),
        .reset(reset),
        .push(push),
        .push_data(mem_q),
        .pop(pop),
        .pop_data(rd_resp_data),
        .full(fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );
endmodule

// File: tb/tb_glb_bank_mem_ctrl.sv
// tb_glb_bank_mem_ctrl: directed checks of arbitration, SRAM drive, read latency, credits and reset
module tb_glb_bank_mem_ctrl;
    logic clk = 1'b0, reset = 1'b1;
    logic wr_req_valid = 1'b0, rd_req_valid = 1'b0, rd_resp_ready = 1'b1;
    logic wr_req_ready, rd_req_ready, rd_resp_valid, mem_ceb, mem_web;
    logic [13:0] wr_addr = '0, rd_addr = '0, mem_a;
    logic [63:0] wr_data = '0, rd_resp_data, mem_bweb, mem_d, mem_q, p1, p2;
    logic [7:0] wr_strb = '0;
    logic [63:0] sram [0:16383];
    int errors = 0, checks = 0, acc;
    always #5 clk = ~clk;
    glb_bank_mem_ctrl dut (
        .clk(clk), .reset(reset),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
        .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready), .rd_resp_data(rd_resp_data),
        .mem_ceb(mem_ceb), .mem_web(mem_web), .mem_bweb(mem_bweb),
        .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q)
    );
    // SRAM model: masked write on the request edge, read data valid 3 cycles after the request cycle
    always @(posedge clk) begin
        if (!mem_ceb) begin
            if (!mem_web) begin
                for (int i = 0; i < 64; i++)
                    if (!mem_bweb[i]) sram[mem_a][i] <= mem_d[i];
            end else begin
                p1 <= sram[mem_a];
            end
        end
        p2 <= p1;
        mem_q <= p2;
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [13:0] a, input logic [63:0] d, input logic [7:0] s);
        wr_req_valid = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
        #1 chk("wr_ready", 64'(wr_req_ready), 64'd1);
        tick();
        wr_req_valid = 1'b0;
    endtask
    task automatic rd_check(input logic [13:0] a, input logic [63:0] exp, input string tag);
        rd_req_valid = 1'b1; rd_addr = a;
        #1 chk({tag, "_rd_ready"}, 64'(rd_req_ready), 64'd1);
        tick();
        rd_req_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            #1 chk({tag, "_early_valid"}, 64'(rd_resp_valid), 64'd0);
            tick();
        end
        #1 chk({tag, "_valid_t4"}, 64'(rd_resp_valid), 64'd1);
        chk({tag, "_data"}, rd_resp_data, exp);
        tick();
    endtask
    initial begin
        // reset with a pending write: memory interface must stay idle
        wr_req_valid = 1'b1; wr_addr = 14'h3; wr_data = 64'h55; wr_strb = 8'hFF;
        tick();
        chk("rst_ceb", 64'(mem_ceb), 64'd1);
        chk("rst_wr_ready", 64'(wr_req_ready), 64'd0);
        chk("rst_bweb", mem_bweb, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_a", 64'(mem_a), 64'd0);
        chk("rst_d", mem_d, 64'd0);
        chk("rst_resp_valid", 64'(rd_resp_valid), 64'd0);
        tick();
        reset = 1'b0; wr_req_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1 chk("idle_ceb", 64'(mem_ceb), 64'd1);
            chk("idle_web", 64'(mem_web), 64'd1);
            chk("idle_bweb", mem_bweb, 64'hFFFF_FFFF_FFFF_FFFF);
            chk("idle_resp_valid", 64'(rd_resp_valid), 64'd0);
            tick();
        end
        // full write then read-back with latency check
        wr_req_valid = 1'b1; wr_addr = 14'h0805; wr_data = 64'hDEADBEEF_CAFEF00D; wr_strb = 8'hFF;
        #1 chk("w1_ready", 64'(wr_req_ready), 64'd1);
        chk("w1_ceb", 64'(mem_ceb), 64'd0);
        chk("w1_web", 64'(mem_web), 64'd0);
        chk("w1_a", 64'(mem_a), 64'h0805);
        chk("w1_d", mem_d, 64'hDEADBEEF_CAFEF00D);
        chk("w1_bweb", mem_bweb, 64'd0);
        tick();
        wr_req_valid = 1'b0;
        rd_req_valid = 1'b1; rd_addr = 14'h0805;
        #1 chk("r1_web", 64'(mem_web), 64'd1);
        chk("r1_a", 64'(mem_a), 64'h0805);
        chk("r1_bweb", mem_bweb, 64'hFFFF_FFFF_FFFF_FFFF);
        rd_check(14'h0805, 64'hDEADBEEF_CAFEF00D, "r1");
        #1 chk("r1_popped", 64'(rd_resp_valid), 64'd0);
        // partial strobe write
        wr(14'h0010, 64'h11111111_11111111, 8'hFF);
        wr_req_valid = 1'b1; wr_addr = 14'h0010; wr_data = 64'hFFFFFFFF_FFFFFFFF; wr_strb = 8'h0F;
        #1 chk("strb_bweb", mem_bweb, 64'hFFFFFFFF_00000000);
        tick();
        wr_req_valid = 1'b0;
        rd_check(14'h0010, 64'h11111111_FFFFFFFF, "strb");
        // contention alternates starting with write
        for (int k = 0; k < 6; k++) begin
            wr_req_valid = 1'b1; wr_addr = 14'(32'h20 + k); wr_data = 64'(k); wr_strb = 8'hFF;
            rd_req_valid = 1'b1; rd_addr = 14'h0805;
            #1 chk("rr_wr_ready", 64'(wr_req_ready), 64'(k % 2 == 0));
            chk("rr_rd_ready", 64'(rd_req_ready), 64'(k % 2 == 1));
            tick();
        end
        wr_req_valid = 1'b0; rd_req_valid = 1'b0;
        repeat (6) tick();
        // credit exhaustion with stalled consumer
        for (int i = 0; i < 6; i++) wr(14'(32'h100 + i), 64'(32'hA0 + i), 8'hFF);
        rd_resp_ready = 1'b0; acc = 0;
        for (int k = 0; k < 6; k++) begin
            rd_req_valid = 1'b1; rd_addr = 14'(32'h100 + acc);
            wr_req_valid = k >= 4; wr_addr = 14'h300; wr_data = 64'(k); wr_strb = 8'hFF;
            #1 chk("cr_rd_ready", 64'(rd_req_ready), 64'(k < 4));
            if (k >= 4) chk("cr_wr_ready", 64'(wr_req_ready), 64'd1);
            if (rd_req_ready) acc++;
            tick();
        end
        chk("cr_accepted", 64'(acc), 64'd4);
        wr_req_valid = 1'b0;
        repeat (3) tick();
        #1 chk("cr_still_blocked", 64'(rd_req_ready), 64'd0);
        chk("cr_resp_valid", 64'(rd_resp_valid), 64'd1);
        rd_req_valid = 1'b0; rd_resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("cr_drain_valid", 64'(rd_resp_valid), 64'd1);
            chk("cr_drain_data", rd_resp_data, 64'(32'hA0 + i));
            tick();
        end
        #1 chk("cr_drained", 64'(rd_resp_valid), 64'd0);
        rd_req_valid = 1'b1; rd_addr = 14'h104;
        #1 chk("cr_resume0", 64'(rd_req_ready), 64'd1);
        tick();
        rd_addr = 14'h105;
        #1 chk("cr_resume1", 64'(rd_req_ready), 64'd1);
        tick();
        rd_req_valid = 1'b0;
        repeat (2) tick();
        chk("cr_r4_valid", 64'(rd_resp_valid), 64'd1);
        chk("cr_r4_data", rd_resp_data, 64'hA4);
        tick();
        chk("cr_r5_valid", 64'(rd_resp_valid), 64'd1);
        chk("cr_r5_data", rd_resp_data, 64'hA5);
        tick();
        chk("cr_empty", 64'(rd_resp_valid), 64'd0);
        // reset with two reads in flight
        rd_req_valid = 1'b1; rd_addr = 14'h0805;
        #1 chk("mr_rd0", 64'(rd_req_ready), 64'd1);
        tick();
        #1 chk("mr_rd1", 64'(rd_req_ready), 64'd1);
        tick();
        reset = 1'b1;
        #1 chk("mr_rst_rd_ready", 64'(rd_req_ready), 64'd0);
        chk("mr_rst_ceb", 64'(mem_ceb), 64'd1);
        tick();
        reset = 1'b0; rd_req_valid = 1'b0;
        #1 chk("mr_credits", 64'(dut.credits), 64'd0);
        for (int k = 0; k < 6; k++) begin
            #1 chk("mr_no_resp", 64'(rd_resp_valid), 64'd0);
            tick();
        end
        wr_req_valid = 1'b1; wr_addr = 14'h40; wr_data = 64'h7; wr_strb = 8'hFF;
        rd_req_valid = 1'b1; rd_addr = 14'h0010;
        #1 chk("mr_first_conflict_wr", 64'(wr_req_ready), 64'd1);
        chk("mr_first_conflict_rd", 64'(rd_req_ready), 64'd0);
        tick();
        wr_req_valid = 1'b0;
        rd_check(14'h0010, 64'h11111111_FFFFFFFF, "mr_after");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
